// File: rtl/dec_scan_seq.sv
// Scan sequencer for the 2-to-4 polarity decoder: steps sel through the four
// outputs in up/down/ping-pong/hold order, with a programmable dwell and gated polarity.
module dec_scan_seq #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             pol_in,
  input  logic             step,
  input  logic             load,
  input  logic [1:0]       load_sel,
  output logic [1:0]       sel,
  output logic             pol,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic             dir, dir_nx;       // 1 = counting down (ping-pong only)
  logic [1:0]       sel_nx;
  logic             pol_nx, tick_nx, wrap_nx;
  logic             do_adv;
  logic [1:0]       adv_sel;
  logic             adv_dir, adv_wrap;

  // Candidate next position if an advance happens this edge.
  always_comb begin
    adv_sel  = sel;
    adv_dir  = dir;
    adv_wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        adv_sel  = sel + 2'd1;
        adv_wrap = (sel == 2'd3);
      end
      MODE_DOWN: begin
        adv_sel  = sel - 2'd1;
        adv_wrap = (sel == 2'd0);
      end
      MODE_PP: begin
        if (sel == 2'd3)      adv_sel = 2'd2;
        else if (sel == 2'd0) adv_sel = 2'd1;
        else if (dir)         adv_sel = sel - 2'd1;
        else                  adv_sel = sel + 2'd1;
        if (adv_sel == 2'd3)      adv_dir = 1'b1;
        else if (adv_sel == 2'd0) adv_dir = 1'b0;
        adv_wrap = (sel == 2'd1) && (adv_sel == 2'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir;
    sel_nx   = sel;
    pol_nx   = pol;
    tick_nx  = 1'b0;
    wrap_nx  = 1'b0;
    do_adv   = 1'b0;
    case (state)
      IDLE: begin
        pol_nx = pol_in;
        if (en) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
        if (step && (mode != MODE_HOLD)) do_adv = 1'b1;
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (mode == MODE_HOLD) begin
          cnt_nx = '0;
        end else if (cnt >= div) begin
          do_adv = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Load overrides any advance or step on the same edge.
    if (load) begin
      sel_nx = load_sel;
      cnt_nx = '0;
      dir_nx = (load_sel == 2'd3);
      pol_nx = pol_in;
    end else if (do_adv) begin
      sel_nx  = adv_sel;
      dir_nx  = adv_dir;
      tick_nx = 1'b1;
      wrap_nx = adv_wrap;
      pol_nx  = pol_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      sel   <= 2'd0;
      pol   <= 1'b1;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dir   <= dir_nx;
      sel   <= sel_nx;
      pol   <= pol_nx;
      tick  <= tick_nx;
      wrap  <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: reset, up scan, ping-pong, polarity gating,
// load-vs-step priority, divider shrink and hold.
module tb_dec_scan_seq;

  logic       clk, rst, en, pol_in, step, load;
  logic [7:0] div;
  logic [1:0] mode, load_sel;
  logic [1:0] sel;
  logic       pol, tick, wrap;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_sel;

  dec_scan_seq #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .mode(mode), .pol_in(pol_in),
    .step(step), .load(load), .load_sel(load_sel),
    .sel(sel), .pol(pol), .tick(tick), .wrap(wrap)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge, outputs are read there too
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0; load_sel = 2'd0;
    div = 8'd0; mode = 2'b00; pol_in = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0; load_sel = 2'd0;
    div = 8'd0; mode = 2'b00; pol_in = 1'b1;
    edge1();
    do_reset();

    // asynchronous reset mid-run with sel = 2
    div = 8'd3; mode = 2'b00; pol_in = 1'b0; en = 1'b1;
    edge1();                       // E0
    repeat (8) edge1();            // advances at E0+4, E0+8
    check("pre_rst_sel", {6'd0, sel}, 8'd2);
    check("pre_rst_tick", {7'd0, tick}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_sel", {6'd0, sel}, 8'd0);
    check("rst_pol", {7'd0, pol}, 8'd1);
    check("rst_tick", {7'd0, tick}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);
    do_reset();

    // up scan, div = 2: changes at E0+3, +6, +9, +12
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_sel = 2'd0;
    div = 8'd2; mode = 2'b00; en = 1'b1;
    edge1();                       // E0
    for (int k = 1; k <= 12; k++) begin
      edge1();
      if (k % 3 == 0) exp_sel = exp_q.pop_front();
      check("up_sel", {6'd0, sel}, {6'd0, exp_sel});
      check("up_tick", {7'd0, tick}, {7'd0, (k % 3 == 0)});
      check("up_wrap", {7'd0, wrap}, {7'd0, (k == 12)});
    end
    do_reset();

    // ping-pong, div = 0
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    div = 8'd0; mode = 2'b10; en = 1'b1;
    edge1();                       // E0
    for (int k = 1; k <= 7; k++) begin
      edge1();
      exp_sel = exp_q.pop_front();
      check("pp_sel", {6'd0, sel}, {6'd0, exp_sel});
      check("pp_tick", {7'd0, tick}, 8'd1);
      check("pp_wrap", {7'd0, wrap}, {7'd0, (k == 6)});
    end
    do_reset();

    // polarity gating, div = 4: pol_in drops at cnt = 1, pol follows at E0+5
    div = 8'd4; mode = 2'b00; pol_in = 1'b1; en = 1'b1;
    edge1();                       // E0
    edge1();                       // cnt = 1
    pol_in = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      edge1();
      check("polg_hold", {7'd0, pol}, 8'd1);
      check("polg_notick", {7'd0, tick}, 8'd0);
    end
    edge1();
    check("polg_tick", {7'd0, tick}, 8'd1);
    check("polg_flip", {7'd0, pol}, 8'd0);
    check("polg_sel", {6'd0, sel}, 8'd1);
    do_reset();

    // load beats step in IDLE, mode down
    mode = 2'b01;
    load = 1'b1; load_sel = 2'd1;
    edge1();
    load = 1'b0;
    check("ld_sel1", {6'd0, sel}, 8'd1);
    check("ld_tick1", {7'd0, tick}, 8'd0);
    step = 1'b1; load = 1'b1; load_sel = 2'd3;
    edge1();
    step = 1'b0; load = 1'b0;
    check("ldstep_sel", {6'd0, sel}, 8'd3);
    check("ldstep_tick", {7'd0, tick}, 8'd0);
    check("ldstep_wrap", {7'd0, wrap}, 8'd0);
    step = 1'b1;
    edge1();
    step = 1'b0;
    check("step_sel", {6'd0, sel}, 8'd2);
    check("step_tick", {7'd0, tick}, 8'd1);
    check("step_wrap", {7'd0, wrap}, 8'd0);
    edge1();
    check("step_tick_pulse", {7'd0, tick}, 8'd0);
    check("step_sel_idle", {6'd0, sel}, 8'd2);
    load = 1'b1; load_sel = 2'd0;
    edge1();
    load = 1'b0; step = 1'b1;
    edge1();
    step = 1'b0;
    check("step_dn_sel", {6'd0, sel}, 8'd3);
    check("step_dn_wrap", {7'd0, wrap}, 8'd1);
    do_reset();

    // divider shrink: div 10 -> 3 with cnt = 7
    div = 8'd10; mode = 2'b00; en = 1'b1;
    edge1();                       // E0
    repeat (7) edge1();            // cnt = 7
    check("shr_sel0", {6'd0, sel}, 8'd0);
    div = 8'd3;
    edge1();
    check("shr_sel1", {6'd0, sel}, 8'd1);
    check("shr_tick1", {7'd0, tick}, 8'd1);
    for (int k = 1; k <= 3; k++) begin
      edge1();
      check("shr_dwell_sel", {6'd0, sel}, 8'd1);
      check("shr_dwell_tick", {7'd0, tick}, 8'd0);
    end
    edge1();
    check("shr_sel2", {6'd0, sel}, 8'd2);
    check("shr_tick2", {7'd0, tick}, 8'd1);
    do_reset();

    // hold mode never advances
    div = 8'd0; mode = 2'b11; en = 1'b1;
    edge1();
    for (int k = 1; k <= 4; k++) begin
      edge1();
      check("hold_sel", {6'd0, sel}, 8'd0);
      check("hold_tick", {7'd0, tick}, 8'd0);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
